fpga_recv_ctrl: RTL and testbench

Frame-level receive controller for the Pi-to-FPGA byte link. It accepts one byte per `byte_valid` strobe from the GPIO bus and parses it as a framed command: sync, command, length, payload and optional checksum. Payload bytes become addressed write strobes into one of four downstream byte buffers, so the Pi can load weight and input memories without the fixed-count, free-running writes used today. The block sits between the GPIO capture logic and the neural-net buffer banks, and reports frame status on the board LEDs.

---
 rtl/fpga_recv_pkg.sv | 21 ++
 rtl/recv_timeout_timer.sv | 37 +++
 rtl/fpga_recv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fpga_recv_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_recv_pkg.sv
// Shared types and constants for the Pi-to-FPGA frame receiver.
package fpga_recv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CSUM
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/recv_timeout_timer.sv
// Mid-frame inactivity timer: flags the cycle whose edge completes
// TIMEOUT_CYCLES consecutive idle cycles while running.
module recv_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic pi_clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // The count reaches TIMEOUT_CYCLES on the edge where expired is high,
    // so the controller reacts on that same edge.
    assign expired = run && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || !run || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge pi_clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fpga_recv_ctrl.sv
// Frame receive controller: SYNC, CMD, LEN, payload writes, optional checksum.
// The checksum byte is expected only when RECV_CHECKSUM_EN is defined.
module fpga_recv_ctrl
    import fpga_recv_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              pi_clk,
    input  logic              rst_n,
    input  logic [7:0]        gpio_pin,
    input  logic              byte_valid,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [5:0]        LED
);

    localparam int MAX_LEN = (1 << ADDR_W) - 1;

    state_e            state_q, state_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    err_e              err_code_q, err_code_d;
    logic [3:0]        ok_count_q, ok_count_d;
    logic              timer_expired;
`ifdef RECV_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // rst_n is active-high and synchronous on this board.
    recv_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .pi_clk (pi_clk),
        .rst    (rst_n),
        .clear  (byte_valid),
        .run    (state_q != IDLE),
        .expired(timer_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        rem_d        = rem_q;
        next_addr_d  = next_addr_q;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        ok_count_d   = ok_count_q;
`ifdef RECV_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (gpio_pin == SYNC_BYTE) begin
                        state_d    = CMD;
                        err_code_d = ERR_NONE;
                    end
                end
                CMD: begin
                    wr_sel_d = gpio_pin[1:0];
                    state_d  = LEN;
`ifdef RECV_CHECKSUM_EN
                    csum_d   = gpio_pin;
`endif
                end
                LEN: begin
`ifdef RECV_CHECKSUM_EN
                    csum_d = csum_q ^ gpio_pin;
`endif
                    if ((gpio_pin != 8'd0) && (int'(gpio_pin) <= MAX_LEN)) begin
                        rem_d       = gpio_pin;
                        next_addr_d = '0;
                        state_d     = PAYLOAD;
                    end else begin
                        state_d     = IDLE;
                        err_code_d  = ERR_LEN;
                        frame_err_d = 1'b1;
                    end
                end
                PAYLOAD: begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = next_addr_q;
                    wr_data_d   = gpio_pin;
                    next_addr_d = next_addr_q + ADDR_W'(1);
                    rem_d       = rem_q - 8'd1;
`ifdef RECV_CHECKSUM_EN
                    csum_d      = csum_q ^ gpio_pin;
                    if (rem_q == 8'd1) begin
                        state_d = CSUM;
                    end
`else
                    if (rem_q == 8'd1) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
`endif
                end
`ifdef RECV_CHECKSUM_EN
                CSUM: begin
                    state_d = IDLE;
                    if (gpio_pin == csum_q) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end else if (timer_expired) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        if (frame_done_d) begin
            ok_count_d = ok_count_q + 4'd1;
        end
    end

    always_ff @(posedge pi_clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            next_addr_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            ok_count_q   <= '0;
`ifdef RECV_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            rem_q        <= rem_d;
            next_addr_q  <= next_addr_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            ok_count_q   <= ok_count_d;
`ifdef RECV_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign LED        = {err_code_q, ok_count_q};

endmodule

// File: tb/tb_fpga_recv_ctrl.sv
// Self-checking bench for fpga_recv_ctrl: vector table, directed frame
// sequences and random byte streams against a stream-level frame parser model.
module tb_fpga_recv_ctrl;

    localparam int         TMO     = 16;
    localparam int         MAX_LEN = 255;
    localparam logic [7:0] SYNC    = 8'hA5;
`ifdef RECV_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic       wr_en;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] ec;
        logic [5:0] led;
    } outs_t;

    typedef struct {
        bit         v;
        logic [7:0] d;
        outs_t      exp;
    } vec_t;

    logic       pi_clk = 1'b0;
    logic       rst_n;
    logic [7:0] gpio_pin;
    logic       byte_valid;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [5:0] LED;

    always #5 pi_clk = ~pi_clk;

    fpga_recv_ctrl #(
        .ADDR_W        (8),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pi_clk    (pi_clk),
        .rst_n     (rst_n),
        .gpio_pin  (gpio_pin),
        .byte_valid(byte_valid),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .err_code  (err_code),
        .LED       (LED)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         sv[$];
    logic [7:0] sd[$];
    outs_t      exp_a[];
    int         obs_addr[$], obs_data[$], obs_sel[$], done_at[$], err_at[$];
    vec_t       tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic outs_t cur_outs();
        outs_t o;
        o = {wr_en, wr_sel, wr_addr, wr_data, busy, frame_done, frame_err, err_code, LED};
        return o;
    endfunction

    function automatic outs_t mk(input logic we, input logic [1:0] s, input logic [7:0] a,
                                 input logic [7:0] d, input logic b, input logic dn,
                                 input logic er, input logic [1:0] ec, input logic [3:0] ok);
        outs_t o;
        o = {we, s, a, d, b, dn, er, ec, ec, ok};
        return o;
    endfunction

    task automatic drive(input bit v, input logic [7:0] d);
        byte_valid = v;
        gpio_pin   = d;
        @(posedge pi_clk);
        #1;
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        gpio_pin   = 8'h00;
        rst_n      = 1'b1;
        @(posedge pi_clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic push(input bit v, input logic [7:0] d);
        sv.push_back(v);
        sd.push_back(d);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 8'h00);
    endtask

    task automatic clear_stream();
        sv.delete();
        sd.delete();
    endtask

    // Mostly back-to-back bytes, sometimes short gaps, rarely gaps around the timeout.
    task automatic gap();
        int r;
        r = $urandom_range(0, 19);
        if (r >= 18)      push_idle($urandom_range(TMO - 1, TMO + 1));
        else if (r >= 12) push_idle($urandom_range(1, 3));
    endtask

    task automatic push_rand_frame();
        logic [7:0] cmd, len, b, x;
        cmd = 8'($urandom);
        len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
        push(1'b1, SYNC);
        gap(); push(1'b1, cmd);
        gap(); push(1'b1, len);
        x = cmd ^ len;
        if (len != 8'd0) begin
            for (int p = 0; p < int'(len); p++) begin
                gap();
                b = 8'($urandom);
                push(1'b1, b);
                x ^= b;
            end
            if (CSUM_EN) begin
                gap();
                if ($urandom_range(0, 4) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                push(1'b1, x);
            end
        end
    endtask

    // Parses the whole byte stream as frames and derives, for each input cycle c,
    // the outputs visible in the cycle after it (starting from the reset state).
    task automatic predict();
        int         n;
        int         sel_set[], addr_set[], data_set[], ec_set[];
        bit         wr[], dn[], er[], bz[];
        int         i, j, k, pos, len, s, a, dd, e, ok;
        logic [7:0] x;
        bit         open;
        n = sv.size();
        sel_set = new[n]; addr_set = new[n]; data_set = new[n]; ec_set = new[n];
        wr = new[n]; dn = new[n]; er = new[n]; bz = new[n];
        for (int c = 0; c < n; c++) begin
            sel_set[c] = -1; addr_set[c] = -1; data_set[c] = -1; ec_set[c] = -1;
        end
        i = 0;
        while (i < n) begin
            if (!(sv[i] && sd[i] == SYNC)) begin
                i++;
                continue;
            end
            ec_set[i] = 0; bz[i] = 1'b1;
            j = i; pos = 0; len = 0; x = 8'h00; open = 1'b1;
            while (open) begin
                k = j + 1;
                while (k < n && k <= j + TMO && !sv[k]) k++;
                if (k < n && k <= j + TMO) begin
                    for (int c = j + 1; c < k; c++) bz[c] = 1'b1;
                    bz[k] = 1'b1;
                    x ^= sd[k];
                    if (pos == 0) begin
                        sel_set[k] = int'(sd[k][1:0]);
                    end else if (pos == 1) begin
                        len = int'(sd[k]);
                        if (len == 0 || len > MAX_LEN) begin
                            bz[k] = 1'b0; er[k] = 1'b1; ec_set[k] = 1; open = 1'b0;
                        end
                    end else if (pos <= len + 1) begin
                        wr[k] = 1'b1; addr_set[k] = pos - 2; data_set[k] = int'(sd[k]);
                        if (pos == len + 1 && !CSUM_EN) begin
                            bz[k] = 1'b0; dn[k] = 1'b1; open = 1'b0;
                        end
                    end else begin
                        // x now folds in the received checksum: zero means it matched.
                        bz[k] = 1'b0;
                        if (x == 8'h00) dn[k] = 1'b1;
                        else begin er[k] = 1'b1; ec_set[k] = 2; end
                        open = 1'b0;
                    end
                    pos++;
                    j = k;
                    if (!open) i = k + 1;
                end else if (j + TMO < n) begin
                    for (int c = j + 1; c < j + TMO; c++) bz[c] = 1'b1;
                    er[j + TMO] = 1'b1; ec_set[j + TMO] = 3;
                    open = 1'b0;
                    i = j + TMO + 1;
                end else begin
                    open = 1'b0;
                    i = n;
                end
            end
        end
        exp_a = new[n];
        s = 0; a = 0; dd = 0; e = 0; ok = 0;
        for (int c = 0; c < n; c++) begin
            if (sel_set[c]  >= 0) s  = sel_set[c];
            if (addr_set[c] >= 0) a  = addr_set[c];
            if (data_set[c] >= 0) dd = data_set[c];
            if (ec_set[c]   >= 0) e  = ec_set[c];
            if (dn[c]) ok = (ok + 1) % 16;
            exp_a[c] = mk(wr[c], 2'(s), 8'(a), 8'(dd), bz[c], dn[c], er[c], 2'(e), 4'(ok));
        end
    endtask

    task automatic run_stream(input string tag);
        push_idle(TMO + 3);
        predict();
        do_reset();
        obs_addr.delete(); obs_data.delete(); obs_sel.delete();
        done_at.delete(); err_at.delete();
        for (int c = 0; c < sv.size(); c++) begin
            drive(sv[c], sd[c]);
            check($sformatf("%s[%0d]", tag, c), {2'b00, cur_outs()}, {2'b00, exp_a[c]});
            if (wr_en) begin
                obs_addr.push_back(int'(wr_addr));
                obs_data.push_back(int'(wr_data));
                obs_sel.push_back(int'(wr_sel));
            end
            if (frame_done) done_at.push_back(c);
            if (frame_err)  err_at.push_back(c);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        bit seen;
        rst_n = 1'b1; byte_valid = 1'b0; gpio_pin = 8'h00;

        do_reset();
        check("reset_state", {2'b00, cur_outs()}, 32'd0);

        // Cycle-by-cycle vectors from reset: junk, bad length, then a one-byte frame.
        tbl.push_back('{1'b1, 8'h00, mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'hFF, mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'hA5, mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'h01, mk(0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'h00, mk(0, 1, 8'h00, 8'h00, 0, 0, 1, 1, 0)});
        tbl.push_back('{1'b0, 8'h00, mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 1, 0)});
        tbl.push_back('{1'b1, 8'hA5, mk(0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'h02, mk(0, 2, 8'h00, 8'h00, 1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 8'h01, mk(0, 2, 8'h00, 8'h00, 1, 0, 0, 0, 0)});
        if (CSUM_EN) begin
            tbl.push_back('{1'b1, 8'h5C, mk(1, 2, 8'h00, 8'h5C, 1, 0, 0, 0, 0)});
            tbl.push_back('{1'b1, 8'h5F, mk(0, 2, 8'h00, 8'h5C, 0, 1, 0, 0, 1)});
        end else begin
            tbl.push_back('{1'b1, 8'h5C, mk(1, 2, 8'h00, 8'h5C, 0, 1, 0, 0, 1)});
        end
        tbl.push_back('{1'b0, 8'h00, mk(0, 2, 8'h00, 8'h5C, 0, 0, 0, 0, 1)});
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].v, tbl[r].d);
            check($sformatf("vec[%0d]", r), {2'b00, cur_outs()}, {2'b00, tbl[r].exp});
        end

        // Good frame; the trailing 01 is the checksum, or ignored junk without one.
        clear_stream();
        foreach (sd[i]) sd[i] = 8'h00;
        push(1, 8'hA5); push(1, 8'h02); push(1, 8'h03); push(1, 8'h11);
        push(1, 8'h22); push(1, 8'h33); push(1, 8'h01);
        run_stream("good");
        check("good_nwr",   32'(obs_addr.size()), 32'd3);
        check("good_addr2", 32'(qat(obs_addr, 2)), 32'd2);
        check("good_data1", 32'(qat(obs_data, 1)), 32'h22);
        check("good_sel0",  32'(qat(obs_sel, 0)), 32'd2);
        check("good_done",  32'(qat(done_at, 0)), CSUM_EN ? 32'd6 : 32'd5);
        check("good_led",   32'(LED), 32'b00_0001);

        // Bad checksum: writes still happen, ok_count unchanged.
        clear_stream();
        push(1, 8'hA5); push(1, 8'h02); push(1, 8'h03); push(1, 8'h11);
        push(1, 8'h22); push(1, 8'h33); push(1, 8'h00);
        run_stream("badcs");
        check("badcs_nwr", 32'(obs_addr.size()), 32'd3);
        check("badcs_err", 32'(err_at.size()), CSUM_EN ? 32'd1 : 32'd0);
        check("badcs_led", 32'(LED), CSUM_EN ? 32'b10_0000 : 32'b00_0001);

        // Bad length.
        clear_stream();
        push(1, 8'hA5); push(1, 8'h01); push(1, 8'h00);
        run_stream("badlen");
        check("badlen_nwr",  32'(obs_addr.size()), 32'd0);
        check("badlen_err",  32'(qat(err_at, 0)), 32'd2);
        check("badlen_led",  32'(LED), 32'b01_0000);
        check("badlen_busy", 32'(busy), 32'd0);

        // Timeout: AA in cycle 3, frame_err visible in cycle 3+16+1.
        clear_stream();
        push(1, 8'hA5); push(1, 8'h01); push(1, 8'h02); push(1, 8'hAA);
        run_stream("tmo");
        check("tmo_nerr", 32'(err_at.size()), 32'd1);
        check("tmo_at",   32'(qat(err_at, 0) + 1), 32'd20);
        check("tmo_code", 32'(err_code), 32'd3);

        // Byte arriving on the 16th idle cycle wins over the timeout.
        clear_stream();
        push(1, 8'hA5); push(1, 8'h01); push(1, 8'h02); push(1, 8'hAA);
        push_idle(TMO - 1); push(1, 8'h55); push(1, 8'hFC);
        run_stream("tmo_edge");
        check("tmoe_nerr",  32'(err_at.size()), 32'd0);
        check("tmoe_ndone", 32'(done_at.size()), 32'd1);
        check("tmoe_data",  32'(qat(obs_data, 1)), 32'h55);

        // Junk then two frames back to back.
        clear_stream();
        push(1, 8'h00); push(1, 8'hFF);
        push(1, 8'hA5); push(1, 8'h01); push(1, 8'h02); push(1, 8'h10); push(1, 8'h20); push(1, 8'h33);
        push(1, 8'hA5); push(1, 8'h03); push(1, 8'h01); push(1, 8'h77); push(1, 8'h75);
        run_stream("b2b");
        check("b2b_ndone", 32'(done_at.size()), 32'd2);
        check("b2b_led",   32'(LED), 32'b00_0010);
        check("b2b_addr",  32'(qat(obs_addr, 2)), 32'd0);
        check("b2b_sel",   32'(qat(obs_sel, 2)), 32'd3);

        // Reset mid-payload abandons the frame silently.
        do_reset();
        drive(1, 8'hA5); drive(1, 8'h01); drive(1, 8'h03); drive(1, 8'h11); drive(1, 8'h22);
        byte_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge pi_clk);
        #1;
        rst_n = 1'b0;
        check("rst_mid_outs", {2'b00, cur_outs()}, 32'd0);
        drive(1, 8'hA5); drive(1, 8'h01); drive(1, 8'h01); drive(1, 8'h9A);
        check("rst_mid_wr", {24'd0, wr_en, wr_addr[6:0]}, {24'd0, 1'b1, 7'd0});
        seen = frame_done;
        drive(1, 8'h9A);
        seen |= frame_done;
        check("rst_mid_done", 32'(seen), 32'd1);
        drive(0, 8'h00);
        check("rst_mid_led", 32'(LED), 32'b00_0001);

        // Random streams of junk, gaps and frames.
        for (int r = 0; r < 5; r++) begin
            clear_stream();
            while (sv.size() < 600) begin
                case ($urandom_range(0, 9))
                    0, 1:    push(1'b1, 8'($urandom));
                    2, 3:    push_idle($urandom_range(1, 3));
                    4:       push_idle($urandom_range(TMO - 2, TMO + 2));
                    default: push_rand_frame();
                endcase
            end
            run_stream($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
